// File: rtl/mux_scan_pkg.sv
// Shared state encoding, mode constants and sizing helper for the scan multiplexer.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2
    } scan_state_e;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_scan_reg_if.sv
// Sample-side bus of the scan multiplexer: controls and channel data in, registered sample out.
interface mux_scan_reg_if
    import mux_scan_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned SEL_W    = clog2_min1(CHANNELS)
);
    logic                      en;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] d;
    logic                      ready;
    logic [WIDTH-1:0]          y;
    logic [SEL_W-1:0]          ch;
    logic                      valid;
    logic                      wrap;

    modport master (
        output en, mode, sel, d, ready,
        input  y, ch, valid, wrap
    );

    modport slave (
        input  en, mode, sel, d, ready,
        output y, ch, valid, wrap
    );
endinterface

// File: rtl/mux_scan_counter.sv
// Modulo-CHANNELS scan counter behind a DWELL prescaler, with parallel load and terminal count.
module mux_scan_counter
    import mux_scan_pkg::*;
#(
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned DWELL    = 1,
    parameter int unsigned SEL_W    = clog2_min1(CHANNELS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [SEL_W-1:0] i_load_val,
    input  logic             i_cnt_en,
    output logic [SEL_W-1:0] o_cnt_c,
    output logic             o_tc_c
);
    localparam int unsigned      DW_W     = clog2_min1(DWELL);
    localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);

    logic [SEL_W-1:0] r_cnt;
    logic [DW_W-1:0]  r_dwell;
    logic [SEL_W-1:0] w_cur_cnt;
    logic [DW_W-1:0]  w_cur_dw;
    logic [SEL_W-1:0] w_cnt_nxt;
    logic [DW_W-1:0]  w_dwell_nxt;
    logic             w_cnt_last;
    logic             w_dw_last;

    // A load takes effect for the same edge's count, so the loaded channel is the one sampled.
    always_comb begin
        w_cur_cnt   = i_load ? i_load_val : r_cnt;
        w_cur_dw    = i_load ? '0 : r_dwell;
        w_cnt_last  = (w_cur_cnt == CNT_LAST);
        w_dw_last   = (w_cur_dw == DW_LAST);
        w_cnt_nxt   = w_cur_cnt;
        w_dwell_nxt = w_cur_dw;
        if (i_cnt_en) begin
            if (w_dw_last) begin
                w_dwell_nxt = '0;
                w_cnt_nxt   = w_cnt_last ? '0 : w_cur_cnt + SEL_W'(1);
            end else begin
                w_dwell_nxt = w_cur_dw + DW_W'(1);
            end
        end
    end

    // Counter and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_dwell <= '0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    assign o_cnt_c = w_cur_cnt;
    assign o_tc_c  = w_cnt_last && w_dw_last;

endmodule

// File: rtl/mux_scan_reg.sv
// Registered channel multiplexer with direct select or dwell-prescaled auto-scan and a ready/valid output.
module mux_scan_reg
    import mux_scan_pkg::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 8,
    parameter int unsigned DWELL    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_scan_reg_if.slave bus
);
    localparam int unsigned      SEL_W   = clog2_min1(CHANNELS);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(CHANNELS - 1);

    scan_state_e      r_state;
    scan_state_e      w_state_nxt;
    logic [WIDTH-1:0] r_y;
    logic [SEL_W-1:0] r_ch;
    logic             r_valid;
    logic             r_wrap;

    logic             w_take;
    logic             w_scan_mode;
    logic             w_enter_scan;
    logic             w_scan_tc_c;
    logic [SEL_W-1:0] w_sel_clamp;
    logic [SEL_W-1:0] w_scan_ch;
    logic [SEL_W-1:0] w_ch;
    logic [WIDTH-1:0] w_y;

    // Out-of-range selects fold onto the last channel.
    assign w_sel_clamp  = (bus.sel > CH_LAST) ? CH_LAST : bus.sel;
    // A held, unaccepted sample blocks everything, including mode changes.
    assign w_take       = bus.en && (!r_valid || bus.ready);
    assign w_scan_mode  = (bus.mode == MODE_SCAN);
    assign w_enter_scan = w_take && w_scan_mode && (r_state != ST_SCAN);

    mux_scan_counter #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL),
        .SEL_W    (SEL_W)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_enter_scan),
        .i_load_val (w_sel_clamp),
        .i_cnt_en   (w_take && w_scan_mode),
        .o_cnt_c    (w_scan_ch),
        .o_tc_c     (w_scan_tc_c)
    );

    assign w_ch = (bus.mode == MODE_DIRECT) ? w_sel_clamp : w_scan_ch;
    assign w_y  = bus.d[32'(w_ch) * WIDTH +: WIDTH];

    // Next state: every sample follows the mode seen on that edge.
    always_comb begin
        w_state_nxt = r_state;
        if (w_take) begin
            w_state_nxt = w_scan_mode ? ST_SCAN : ST_DIRECT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output sample register; an accepted sample with nothing new behind it drops valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else if (w_take) begin
            r_y     <= w_y;
            r_ch    <= w_ch;
            r_valid <= 1'b1;
            r_wrap  <= w_scan_mode && w_scan_tc_c;
        end else if (bus.ready) begin
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end
    end

    assign bus.y     = r_y;
    assign bus.ch    = r_ch;
    assign bus.valid = r_valid;
    assign bus.wrap  = r_wrap;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Four configurations of mux_scan_reg driven in lockstep and checked against a linear-position scan model.
module tb_mux_scan_reg;
    localparam int NI = 4;
    localparam int W  = 4;

    int c_tab  [NI] = '{8, 5, 4, 6};
    int d_tab  [NI] = '{1, 1, 3, 1};
    int sw_tab [NI] = '{3, 3, 2, 3};
    int seq42  [6]  = '{3, 4, 0, 1, 2, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        ready;
    logic [3:0]  sel_raw;
    logic [63:0] d_raw;

    int n_vec;
    int n_err;

    logic [3:0] obs_y  [NI];
    logic [3:0] obs_ch [NI];
    logic       obs_v  [NI];
    logic       obs_w  [NI];

    int         m_pos  [NI];
    int         m_ch   [NI];
    logic [3:0] m_y    [NI];
    bit         m_v    [NI];
    bit         m_w    [NI];
    bit         m_scan [NI];

    always #5 clk = ~clk;

    mux_scan_reg_if #(.WIDTH(W), .CHANNELS(8)) if0 ();
    mux_scan_reg_if #(.WIDTH(W), .CHANNELS(5)) if1 ();
    mux_scan_reg_if #(.WIDTH(W), .CHANNELS(4)) if2 ();
    mux_scan_reg_if #(.WIDTH(W), .CHANNELS(6)) if3 ();

    mux_scan_reg #(.WIDTH(W), .CHANNELS(8), .DWELL(1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    mux_scan_reg #(.WIDTH(W), .CHANNELS(5), .DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    mux_scan_reg #(.WIDTH(W), .CHANNELS(4), .DWELL(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    mux_scan_reg #(.WIDTH(W), .CHANNELS(6), .DWELL(1)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    assign if0.en = en;  assign if0.mode = mode;  assign if0.ready = ready;
    assign if1.en = en;  assign if1.mode = mode;  assign if1.ready = ready;
    assign if2.en = en;  assign if2.mode = mode;  assign if2.ready = ready;
    assign if3.en = en;  assign if3.mode = mode;  assign if3.ready = ready;
    assign if0.sel = sel_raw[2:0];  assign if0.d = d_raw[31:0];
    assign if1.sel = sel_raw[2:0];  assign if1.d = d_raw[19:0];
    assign if2.sel = sel_raw[1:0];  assign if2.d = d_raw[15:0];
    assign if3.sel = sel_raw[2:0];  assign if3.d = d_raw[23:0];

    assign obs_y[0] = if0.y;  assign obs_ch[0] = {1'b0, if0.ch};  assign obs_v[0] = if0.valid;  assign obs_w[0] = if0.wrap;
    assign obs_y[1] = if1.y;  assign obs_ch[1] = {1'b0, if1.ch};  assign obs_v[1] = if1.valid;  assign obs_w[1] = if1.wrap;
    assign obs_y[2] = if2.y;  assign obs_ch[2] = {2'b0, if2.ch};  assign obs_v[2] = if2.valid;  assign obs_w[2] = if2.wrap;
    assign obs_y[3] = if3.y;  assign obs_ch[3] = {1'b0, if3.ch};  assign obs_v[3] = if3.valid;  assign obs_w[3] = if3.wrap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NI; i++) begin
            m_pos[i] = 0; m_ch[i] = 0; m_y[i] = '0;
            m_v[i] = 1'b0; m_w[i] = 1'b0; m_scan[i] = 1'b0;
        end
    endfunction

    // Scan position is one linear index over CHANNELS*DWELL sample slots.
    function automatic void model_edge();
        int c;
        int dw;
        int s;
        int chn;
        for (int i = 0; i < NI; i++) begin
            c  = c_tab[i];
            dw = d_tab[i];
            s  = int'(sel_raw) % (1 << sw_tab[i]);
            if (s > c - 1) s = c - 1;
            if (en && (!m_v[i] || ready)) begin
                if (mode) begin
                    if (!m_scan[i]) m_pos[i] = s * dw;
                    chn      = m_pos[i] / dw;
                    m_w[i]   = (m_pos[i] == c * dw - 1);
                    m_pos[i] = (m_pos[i] + 1) % (c * dw);
                    m_scan[i] = 1'b1;
                end else begin
                    chn       = s;
                    m_w[i]    = 1'b0;
                    m_scan[i] = 1'b0;
                end
                m_ch[i] = chn;
                m_y[i]  = d_raw[chn*4 +: 4];
                m_v[i]  = 1'b1;
            end else if (m_v[i] && ready) begin
                m_v[i] = 1'b0;
                m_w[i] = 1'b0;
            end
        end
    endfunction

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            check_eq($sformatf("y[%0d]", i),     32'(obs_y[i]),  32'(m_y[i]));
            check_eq($sformatf("ch[%0d]", i),    32'(obs_ch[i]), 32'(m_ch[i]));
            check_eq($sformatf("valid[%0d]", i), 32'(obs_v[i]),  32'(m_v[i]));
            check_eq($sformatf("wrap[%0d]", i),  32'(obs_w[i]),  32'(m_w[i]));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] sy;
        int         sc;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; ready = 1'b1; sel_raw = '0; d_raw = '0;
        model_reset();
        #2;
        compare_all();
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();

        // Direct select of channel 5 with d[k] = k+1.
        for (int k = 0; k < 16; k++) d_raw[k*4 +: 4] = 4'(k + 1);
        en = 1'b1; mode = 1'b0; sel_raw = 4'd5; ready = 1'b1;
        cycle();
        check_eq("dir_y", 32'(obs_y[0]), 6);
        check_eq("dir_ch", 32'(obs_ch[0]), 5);
        check_eq("dir_valid", 32'(obs_v[0]), 1);

        // Clamp of sel=7 on six channels, then scan from the clamped start.
        sel_raw = 4'd7;
        cycle();
        check_eq("clamp_ch", 32'(obs_ch[3]), 5);
        check_eq("clamp_y", 32'(obs_y[3]), 6);
        mode = 1'b1;
        cycle();
        check_eq("sw_first_ch", 32'(obs_ch[3]), 5);
        cycle();
        check_eq("sw_second_ch", 32'(obs_ch[3]), 0);

        // Five-channel wrap starting at 3.
        mode = 1'b0; sel_raw = 4'd3;
        cycle();
        mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cycle();
            check_eq($sformatf("wrap5_ch%0d", k), 32'(obs_ch[1]), 32'(seq42[k]));
            check_eq($sformatf("wrap5_w%0d", k), 32'(obs_w[1]), (seq42[k] == 4) ? 1 : 0);
        end

        // Dwell of three on four channels.
        mode = 1'b0; sel_raw = 4'd0;
        cycle();
        mode = 1'b1;
        for (int k = 0; k < 13; k++) begin
            cycle();
            check_eq($sformatf("dwell_ch%0d", k), 32'(obs_ch[2]), 32'((k / 3) % 4));
            check_eq($sformatf("dwell_w%0d", k), 32'(obs_w[2]), (k == 11) ? 1 : 0);
        end

        // Stall for four cycles with changing data.
        cycle();
        sy = m_y[1];
        sc = m_ch[1];
        ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d_raw = {$urandom, $urandom};
            cycle();
            check_eq("stall_y", 32'(obs_y[1]), 32'(sy));
            check_eq("stall_ch", 32'(obs_ch[1]), 32'(sc));
            check_eq("stall_valid", 32'(obs_v[1]), 1);
        end
        ready = 1'b1;
        cycle();
        check_eq("resume_ch", 32'(obs_ch[1]), 32'((sc + 1) % 5));

        // Reset asserted while scanning channel 2.
        for (int t = 0; t < 12 && m_ch[1] != 2; t++) cycle();
        check_eq("reach_ch2", 32'(obs_ch[1]), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_y", 32'(obs_y[1]), 0);
        check_eq("rst_ch", 32'(obs_ch[1]), 0);
        check_eq("rst_valid", 32'(obs_v[1]), 0);
        check_eq("rst_wrap", 32'(obs_w[1]), 0);
        compare_all();
        mode = 1'b1; sel_raw = 4'd1;
        cycle();
        rst_n = 1'b1;
        cycle();
        check_eq("post_rst_ch", 32'(obs_ch[1]), 1);
        check_eq("post_rst_valid", 32'(obs_v[1]), 1);

        // Randomised traffic with occasional stalls, mode flips and resets.
        for (int n = 0; n < 2000; n++) begin
            en    = ($urandom_range(0, 9) != 0);
            ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 7) == 0) sel_raw = 4'($urandom);
            d_raw = {$urandom, $urandom};
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
            end else begin
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_reg.md
MUX_SCAN_REG -- requirements
Module: mux_scan_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, bits per channel, legal range 1..16.
REQ-002 The block SHALL have parameter CHANNELS, default 8, number of input channels, legal range 2..16, not restricted to powers of two.
REQ-003 The block SHALL have parameter DWELL, default 1, cycles spent on each channel in scan mode, legal range 1..256.
REQ-004 The block SHALL have derived localparam SEL_W = max(1, clog2(CHANNELS)).
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset; assertion is immediate, release is synchronised to clk by the integrator.
REQ-007 en  in  1  sample enable; when low, all state holds.
REQ-008 mode  in  1  0 = direct select, 1 = auto-scan.
REQ-009 sel  in  SEL_W  channel index used in direct mode and as the scan start point.
REQ-010 d  in  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 ready  in  1  downstream accept; a low ready stalls the block.
REQ-012 y  out  WIDTH  registered selected data.
REQ-013 ch  out  SEL_W  index of the channel held in y.
REQ-014 valid  out  1  y/ch hold a new sample not yet accepted.
REQ-015 wrap  out  1  one-cycle pulse, coincident with valid, when the sample came from channel CHANNELS-1 in scan mode.

Function
REQ-016 The datapath latency SHALL be one cycle: a sample taken at edge N appears on y/ch/valid after edge N.
REQ-017 A sample SHALL be taken on an edge where en=1 and either valid=0 or ready=1.
REQ-018 When valid=1 and ready=0, y, ch, valid, wrap and the scan counter SHALL hold.
REQ-019 When valid=1, ready=1 and no sample is taken (en=0), valid SHALL clear on that edge.
REQ-020 In direct mode, the sample SHALL be d[sel]; a sel value >= CHANNELS SHALL select channel CHANNELS-1.
REQ-021 The scan state machine SHALL have three states: IDLE, DIRECT and SCAN.
REQ-022 Reset SHALL enter IDLE.
REQ-023 From IDLE, the state SHALL go to DIRECT or SCAN per mode on the first edge with en=1.
REQ-024 SCAN to DIRECT SHALL occur when mode=0 at a sample edge.
REQ-025 DIRECT to SCAN SHALL occur when mode=1 at a sample edge.
REQ-026 On entry to SCAN, the scan counter SHALL load sel, clamped as in REQ-020, and the dwell counter SHALL load 0.
REQ-027 In SCAN, the sampled channel SHALL be the scan counter value.
REQ-028 In SCAN, the dwell counter SHALL increment per sample.
REQ-029 In SCAN, when the dwell counter reaches DWELL-1, the dwell counter SHALL return to 0 and the scan counter SHALL advance.
REQ-030 The scan counter SHALL wrap from CHANNELS-1 to 0, never visiting indices >= CHANNELS.
REQ-031 wrap SHALL assert only for a sample of channel CHANNELS-1 whose dwell index is DWELL-1.
REQ-032 A mode change and a stall in the same cycle SHALL both be deferred until the stall releases; the stall has priority.
REQ-033 Changes to d while stalled SHALL NOT alter y.

Reset
REQ-034 While rst_n=0, the block SHALL drive y=0, ch=0, valid=0, wrap=0, state IDLE, scan counter 0 and dwell counter 0.
REQ-035 Reset asserted mid-scan or mid-stall SHALL discard the pending sample with no output glitch beyond the asynchronous clear.
REQ-036 The first sample after reset release SHALL follow REQ-023.

Structure
REQ-037 Package mux_scan_pkg SHALL hold the state enum (IDLE/DIRECT/SCAN), the mode encoding constants and a clog2 helper function.
REQ-038 One sub-module, mux_scan_counter, SHALL implement the modulo-CHANNELS scan counter with the DWELL prescaler, load, enable and terminal-count output, in the style of a 74AC161 chain.
REQ-039 The channel mux SHALL be written as a plain indexed select so synthesis maps it onto 74AC151/74AC153 cells.
REQ-040 No latches or combinational feedback SHALL exist in the block.

Verification
REQ-041 The bench SHALL cover direct select: CHANNELS=8, WIDTH=4, d[k]=k+1, mode=0, sel=5, ready=1, en=1 -> y=6, ch=5, valid=1 one cycle after en.
REQ-042 The bench SHALL cover non-power-of-two wrap: CHANNELS=5, DWELL=1, mode=1, sel=3 -> ch sequence 3,4,0,1,2,3, with wrap high only on ch=4.
REQ-043 The bench SHALL cover dwell: CHANNELS=4, DWELL=3, sel=0 -> ch 0,0,0,1,1,1,2,...; wrap on the third ch=3 sample only.
REQ-044 The bench SHALL cover stall: scan running, ready=0 for 4 cycles while d toggles -> y, ch, valid and wrap frozen; the sequence resumes at the next channel after ready=1.
REQ-045 The bench SHALL cover reset mid-scan: rst_n pulsed low at ch=2 -> all outputs 0 immediately; after release with mode=1, sel=1, the first sample has ch=1.
REQ-046 The bench SHALL cover clamp and mode switch: CHANNELS=6, mode=0, sel=7 -> ch=5; switch to mode=1 -> scan starts at 5, then 0.
